// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small byte FIFO.
//
// Register window (BASE_ADDR must have its low four bits clear):
//   BASE+0 TXDATA  write pushes wdata_i[7:0]; reads 0
//   BASE+4 STATUS  read {28'b0, overflow, fifo_full, fifo_empty, tx_busy}; any write clears overflow
//   BASE+8 CTRL    bit0 enable (reset 1); other bits read 0
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   addr_i       memory address
//   wdata_i      store data
//   mem_wr_i     1 = write, 0 = read
//   sel_o        combinational window hit; selects rdata_o at the top level
//   rdata_o      registered read data (one-cycle latency)
//   tx_o         serial line, idle high, driven from a flop
//   tx_busy_o    a frame is in progress
//   fifo_full_o  FIFO holds FIFO_DEPTH entries
module mmio_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        mem_wr_i,
    output logic        sel_o,
    output logic [31:0] rdata_o,
    output logic        tx_o,
    output logic        tx_busy_o,
    output logic        fifo_full_o
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

    localparam logic [CntW-1:0]  DepthCnt = CntW'(FIFO_DEPTH);
    localparam logic [BaudW-1:0] BaudMax  = BaudW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    // ------------------------------------------------------------------
    // Address decode and write qualification
    // ------------------------------------------------------------------
    logic [1:0] reg_idx;
    logic       hit;
    logic       wr_act;
    logic       wr_first;
    logic       push_req;
    logic       status_wr;
    logic       ctrl_wr;

    logic        last_wr_q;
    logic [31:0] last_addr_q;

    assign reg_idx = addr_i[3:2];
    assign hit     = (addr_i[31:4] == BASE_ADDR[31:4]) && (reg_idx != 2'd3);
    assign sel_o   = hit;
    assign wr_act  = mem_wr_i & hit;
    // The multicycle control holds mem_wr for several states; act only on the
    // first cycle of a given (write, address) pair.
    assign wr_first  = wr_act & ~(last_wr_q && (last_addr_q == addr_i));
    assign push_req  = wr_first && (reg_idx == 2'd0);
    assign status_wr = wr_first && (reg_idx == 2'd1);
    assign ctrl_wr   = wr_first && (reg_idx == 2'd2);

    logic unused_bits;
    assign unused_bits = ^{wdata_i[31:8], addr_i[1:0]};

    // ------------------------------------------------------------------
    // FIFO and control/status state
    // ------------------------------------------------------------------
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            enable_q, enable_d;
    logic            fifo_empty;
    logic            fifo_full;
    logic            pop;
    logic            push_ok;

    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == DepthCnt);
    assign fifo_full_o = fifo_full;
    // A pop in the same cycle frees a slot, so a push while full still lands.
    assign push_ok     = push_req && (!fifo_full || pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        enable_d   = enable_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (status_wr) begin
            overflow_d = 1'b0;
        end else if (push_req && !push_ok) begin
            overflow_d = 1'b1;
        end
        if (ctrl_wr) enable_d = wdata_i[0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= 8'h00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            enable_q    <= 1'b1;
            last_wr_q   <= 1'b0;
            last_addr_q <= '0;
        end else begin
            if (push_ok) mem_q[wr_ptr_q] <= wdata_i[7:0];
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            enable_q    <= enable_d;
            last_wr_q   <= wr_act;
            last_addr_q <= addr_i;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_e          state_q;
    logic [BaudW-1:0] baud_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic            tx_q;
    logic            baud_end;
    logic            frame_go;

    assign baud_end  = (baud_q == BaudMax);
    assign frame_go  = enable_q && !fifo_empty;
    assign pop       = ((state_q == StIdle) && frame_go) ||
                       ((state_q == StStop) && baud_end && frame_go);
    assign tx_o      = tx_q;
    assign tx_busy_o = (state_q != StIdle);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    tx_q   <= 1'b1;
                    baud_q <= '0;
                    if (pop) begin
                        shift_q <= mem_q[rd_ptr_q];
                        state_q <= StStart;
                        tx_q    <= 1'b0;
                    end
                end
                StStart: begin
                    if (baud_end) begin
                        baud_q    <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= StData;
                        tx_q      <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                StData: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= StStop;
                            tx_q    <= 1'b1;
                        end else begin
                            // Present the next bit in the same edge as the shift.
                            shift_q   <= {1'b0, shift_q[7:1]};
                            tx_q      <= shift_q[1];
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                StStop: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (pop) begin
                            // Chain straight into the next start bit, no idle gap.
                            shift_q <= mem_q[rd_ptr_q];
                            state_q <= StStart;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registered read data
    // ------------------------------------------------------------------
    logic [31:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = 32'h0;
        if (hit) begin
            case (reg_idx)
                2'd1:    rdata_d = {28'b0, overflow_q, fifo_full, fifo_empty, tx_busy_o};
                2'd2:    rdata_d = {31'b0, enable_q};
                default: rdata_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed self-checking bench for mmio_uart_tx with CLKS_PER_BIT=4, depth 4.
// A background receiver decodes tx into rx_q for scenarios where frames overlap stimulus.
module tb_mmio_uart_tx;

    localparam int unsigned Cpb = 4;
    localparam logic [31:0] Base   = 32'hFFFF_0000;
    localparam logic [31:0] TxAddr = Base;
    localparam logic [31:0] StAddr = Base + 32'd4;
    localparam logic [31:0] CtAddr = Base + 32'd8;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_wr;
    logic        sel;
    logic [31:0] rdata;
    logic        tx;
    logic        tx_busy;
    logic        fifo_full;

    int checks;
    int errors;

    mmio_uart_tx #(
        .CLKS_PER_BIT(Cpb),
        .FIFO_DEPTH  (4),
        .BASE_ADDR   (Base)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .mem_wr_i   (mem_wr),
        .sel_o      (sel),
        .rdata_o    (rdata),
        .tx_o       (tx),
        .tx_busy_o  (tx_busy),
        .fifo_full_o(fifo_full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Background UART receiver: samples mid-bit of each data bit.
    logic [7:0] rx_q[$];
    logic [7:0] mon_byte;
    int         mon_pos;
    logic       mon_busy;

    initial begin
        mon_busy = 1'b0;
        mon_pos  = 0;
        mon_byte = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                mon_busy = 1'b0;
            end else if (!mon_busy) begin
                if (tx === 1'b0) begin
                    mon_busy = 1'b1;
                    mon_pos  = 0;
                end
            end else begin
                mon_pos++;
                if (mon_pos >= 6 && mon_pos <= 34 && (mon_pos % 4) == 2)
                    mon_byte[(mon_pos - 6) / 4] = tx;
                if (mon_pos == 38) begin
                    rx_q.push_back(mon_byte);
                    mon_busy = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr   = a;
        wdata  = d;
        mem_wr = 1'b1;
        tick();
        mem_wr = 1'b0;
        addr   = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr   = a;
        mem_wr = 1'b0;
        tick();
        d    = rdata;
        addr = 32'h0;
    endtask

    // Waits up to max_wait extra cycles for the start bit, then checks all 10*Cpb samples.
    task automatic recv_frame(input logic [7:0] b, input int max_wait, input string tag);
        int   waited;
        logic exp_bit;
        int   slot;
        waited = 0;
        tick();
        while (tx !== 1'b0 && waited < max_wait) begin
            tick();
            waited++;
        end
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL %s start: tx=%b after %0d cycles, required 0", tag, tx, waited);
            return;
        end
        for (int i = 1; i < 10 * int'(Cpb); i++) begin
            tick();
            slot = i / int'(Cpb);
            if (slot == 0)      exp_bit = 1'b0;
            else if (slot == 9) exp_bit = 1'b1;
            else                exp_bit = b[slot-1];
            checks++;
            if (tx !== exp_bit) begin
                errors++;
                $display("FAIL %s sample %0d: tx=%b, required %b", tag, i, tx, exp_bit);
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n  = 1'b0;
        addr   = 32'h0;
        wdata  = 32'h0;
        mem_wr = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
        checks++;
        if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
        checks++;
        if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", fifo_full); end
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        bus_read(StAddr, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL reset_status: got %h want 00000002", d); end
        bus_read(CtAddr, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL reset_ctrl: got %h want 00000001", d); end
        bus_read(TxAddr, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL txdata_read: got %h want 0", d); end
    endtask

    task automatic test_decode();
        logic [31:0] d;
        addr = Base + 32'd12;
        #1;
        checks++;
        if (sel !== 1'b0) begin errors++; $display("FAIL sel_slot3: got %b want 0", sel); end
        addr = CtAddr;
        #1;
        checks++;
        if (sel !== 1'b1) begin errors++; $display("FAIL sel_ctrl: got %b want 1", sel); end
        addr = 32'h1000_0004;
        #1;
        checks++;
        if (sel !== 1'b0) begin errors++; $display("FAIL sel_outside: got %b want 0", sel); end
        bus_read(32'hFFFE_0004, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL read_outside: got %h want 0", d); end
    endtask

    task automatic test_single_frame();
        bus_write(TxAddr, 32'h0000_00A5);
        checks++;
        if (tx !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_pre: tx=%b busy=%b, required 1/0", tx, tx_busy);
        end
        recv_frame(8'hA5, 0, "single_frame");
        checks++;
        if (tx_busy !== 1'b1) begin errors++; $display("FAIL single_busy_end: got %b want 1", tx_busy); end
        tick();
        checks++;
        if (tx_busy !== 1'b0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL single_idle: busy=%b tx=%b, required 0/1", tx_busy, tx);
        end
    endtask

    task automatic test_held_write();
        logic [31:0] d;
        int          waited;
        rx_q.delete();
        addr   = TxAddr;
        wdata  = 32'h0000_0055;
        mem_wr = 1'b1;
        repeat (3) tick();
        mem_wr = 1'b0;
        addr   = 32'h0;
        waited = 0;
        while (rx_q.size() < 1 && waited < 100) begin tick(); waited++; end
        repeat (60) tick();
        checks++;
        if (rx_q.size() != 1) begin
            errors++;
            $display("FAIL held_count: got %0d frames want 1", rx_q.size());
        end
        checks++;
        if (rx_q.size() > 0 && rx_q[0] !== 8'h55) begin
            errors++;
            $display("FAIL held_byte: got %h want 55", rx_q[0]);
        end
        bus_read(StAddr, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL held_status: got %h want 00000002", d); end
    endtask

    task automatic test_full_overflow();
        logic [31:0] d;
        logic [7:0]  bytes[5];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        bus_write(CtAddr, 32'h0);
        tick();
        bus_read(CtAddr, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL ctrl_clear: got %h want 0", d); end
        for (int i = 0; i < 5; i++) begin
            bus_write(TxAddr, {24'h0, bytes[i]});
            tick();
        end
        checks++;
        if (fifo_full !== 1'b1 || tx_busy !== 1'b0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL full_flags: full=%b busy=%b tx=%b, required 1/0/1", fifo_full, tx_busy, tx);
        end
        bus_read(StAddr, d);
        checks++;
        if (d !== 32'hC) begin errors++; $display("FAIL status_overflow: got %h want 0000000c", d); end
        bus_write(StAddr, 32'h0);
        bus_read(StAddr, d);
        checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL status_cleared: got %h want 00000004", d); end
        bus_write(CtAddr, 32'h1);
        recv_frame(8'h11, 0, "b2b_0");
        recv_frame(8'h22, 0, "b2b_1");
        recv_frame(8'h33, 0, "b2b_2");
        recv_frame(8'h44, 0, "b2b_3");
        tick();
        checks++;
        if (tx_busy !== 1'b0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b tx=%b, required 0/1", tx_busy, tx);
        end
        bus_read(StAddr, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL b2b_status: got %h want 00000002", d); end
    endtask

    task automatic test_push_during_pop();
        logic [31:0] d;
        logic [7:0]  bytes[6];
        int          waited;
        bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
        bus_write(CtAddr, 32'h0);
        tick();
        rx_q.delete();
        for (int i = 0; i < 4; i++) begin
            bus_write(TxAddr, {24'h0, bytes[i]});
            tick();
        end
        bus_write(CtAddr, 32'h1);          // edge M; first pop at M+1
        tick();                            // M+1
        bus_write(TxAddr, {24'h0, bytes[4]}); // M+2: refills to full
        checks++;
        if (fifo_full !== 1'b1) begin errors++; $display("FAIL pp_full: got %b want 1", fifo_full); end
        repeat (38) tick();                // now just after M+40
        bus_write(TxAddr, {24'h0, bytes[5]}); // M+41: coincides with STOP->START pop
        bus_read(StAddr, d);
        checks++;
        if (d !== 32'h5) begin errors++; $display("FAIL pp_status: got %h want 00000005", d); end
        waited = 0;
        while (rx_q.size() < 6 && waited < 400) begin tick(); waited++; end
        repeat (20) tick();
        checks++;
        if (rx_q.size() != 6) begin
            errors++;
            $display("FAIL pp_count: got %0d frames want 6", rx_q.size());
        end
        for (int i = 0; i < 6; i++) begin
            if (i < rx_q.size()) begin
                checks++;
                if (rx_q[i] !== bytes[i]) begin
                    errors++;
                    $display("FAIL pp_byte%0d: got %h want %h", i, rx_q[i], bytes[i]);
                end
            end
        end
        bus_read(StAddr, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL pp_final_status: got %h want 00000002", d); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        int          highs_missed;
        bus_write(TxAddr, 32'h81);
        tick();
        bus_write(TxAddr, 32'h42);
        tick();
        bus_write(TxAddr, 32'h24);
        repeat (8) tick();
        checks++;
        if (tx_busy !== 1'b1) begin errors++; $display("FAIL rmf_pre_busy: got %b want 1", tx_busy); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL rmf_async: tx=%b busy=%b, required 1/0", tx, tx_busy);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        bus_read(StAddr, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL rmf_status: got %h want 00000002", d); end
        rx_q.delete();
        highs_missed = 0;
        repeat (100) begin
            tick();
            if (tx !== 1'b1) highs_missed++;
        end
        checks++;
        if (highs_missed != 0 || rx_q.size() != 0) begin
            errors++;
            $display("FAIL rmf_quiet: low samples %0d frames %0d, required 0/0",
                     highs_missed, rx_q.size());
        end
        bus_read(CtAddr, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL rmf_ctrl: got %h want 00000001", d); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_decode();
        test_single_frame();
        test_held_write();
        test_full_overflow();
        test_push_during_pop();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
